cla_pipe_adder: RTL



---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla_pipe_adder_if.sv | 30 +++
 rtl/cla4.sv | 30 +++
 rtl/cla_pipe_adder.sv | 112 +++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the sliced carry-lookahead pipeline adder.
// The stage struct is sized for the widest legal adder; narrower builds leave the upper bits zero.
package cla_pkg;

    localparam int SLICE_W     = 4;
    localparam int N_SLICE_MAX = 8;
    localparam int W_MAX       = SLICE_W * N_SLICE_MAX;

    function automatic int data_width(input int n_slice);
        return SLICE_W * n_slice;
    endfunction

    typedef struct packed {
        logic             v;
        logic             c;
        logic [W_MAX-1:0] sum;
        logic [W_MAX-1:0] a;
        logic [W_MAX-1:0] b;
        logic             a_msb;
        logic             b_msb;
    } stage_t;

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
interface cla_pipe_adder_if
    import cla_pkg::*;
#(
    parameter int N_SLICE = 4
);
    localparam int W = data_width(N_SLICE);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;

    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );

endinterface

// File: rtl/cla4.sv
// 4-bit carry-lookahead slice with group generate/propagate outputs.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       gg,
    output logic       pg
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = gg | (pg & ci);

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pg = &p;

    assign s  = p ^ c[3:0];
    assign co = c[4];

endmodule

// File: rtl/cla_pipe_adder.sv
// Handshaked adder: one cla4 slice per pipeline stage, carry registered between slices.
// Stalled stages hold; empty stages refill even while downstream is blocked.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int N_SLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cla_pipe_adder_if.slave       bus
);
    localparam int W = data_width(N_SLICE);

    stage_t             stg_p [1:N_SLICE];
    stage_t             nxt_p [1:N_SLICE];
    logic [N_SLICE:1]   adv;
    logic [N_SLICE:1]   load;
    logic               in_ready;

    logic [SLICE_W-1:0] sl_a [N_SLICE];
    logic [SLICE_W-1:0] sl_b [N_SLICE];
    logic [SLICE_W-1:0] sl_s [N_SLICE];
    logic [N_SLICE-1:0] sl_ci;
    logic [N_SLICE-1:0] sl_co;
    logic [N_SLICE-1:0] gg_unused;
    logic [N_SLICE-1:0] pg_unused;

    // Advance ripples back from the output: a stage moves if the next one is empty or moving.
    always_comb begin
        adv          = '0;
        adv[N_SLICE] = stg_p[N_SLICE].v && bus.out_ready;
        for (int k = N_SLICE - 1; k >= 1; k--) begin
            adv[k] = stg_p[k].v && (!stg_p[k+1].v || adv[k+1]);
        end
    end

    assign in_ready     = !stg_p[1].v || adv[1];
    assign bus.in_ready = in_ready;
    assign load         = {adv[N_SLICE-1:1], bus.in_valid && in_ready};

    always_comb begin
        sl_a[0]  = bus.a[SLICE_W-1:0];
        sl_b[0]  = bus.b[SLICE_W-1:0];
        sl_ci[0] = bus.ci;
        for (int k = 1; k < N_SLICE; k++) begin
            sl_a[k]  = stg_p[k].a[k*SLICE_W +: SLICE_W];
            sl_b[k]  = stg_p[k].b[k*SLICE_W +: SLICE_W];
            sl_ci[k] = stg_p[k].c;
        end
    end

    for (genvar k = 0; k < N_SLICE; k++) begin : g_slice
        cla4 u_cla4 (
            .a  (sl_a[k]),
            .b  (sl_b[k]),
            .ci (sl_ci[k]),
            .s  (sl_s[k]),
            .co (sl_co[k]),
            .gg (gg_unused[k]),
            .pg (pg_unused[k])
        );
    end

    // Stage inputs: slice 0 from the bus, slice k folded into the beat held in stage k.
    always_comb begin
        nxt_p[1]                    = '0;
        nxt_p[1].v                  = 1'b1;
        nxt_p[1].c                  = sl_co[0];
        nxt_p[1].sum[SLICE_W-1:0]   = sl_s[0];
        nxt_p[1].a[W-1:SLICE_W]     = bus.a[W-1:SLICE_W];
        nxt_p[1].b[W-1:SLICE_W]     = bus.b[W-1:SLICE_W];
        nxt_p[1].a_msb              = bus.a[W-1];
        nxt_p[1].b_msb              = bus.b[W-1];
        for (int k = 1; k < N_SLICE; k++) begin
            nxt_p[k+1]                             = stg_p[k];
            nxt_p[k+1].c                           = sl_co[k];
            nxt_p[k+1].sum[k*SLICE_W +: SLICE_W]   = sl_s[k];
            nxt_p[k+1].a[k*SLICE_W +: SLICE_W]     = '0;
            nxt_p[k+1].b[k*SLICE_W +: SLICE_W]     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= N_SLICE; k++) begin
                stg_p[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= N_SLICE; k++) begin
                if (load[k]) begin
                    stg_p[k] <= nxt_p[k];
                end else if (adv[k]) begin
                    stg_p[k].v <= 1'b0;
                end
            end
        end
    end

    // Output stage drives the bus directly.
    logic [W-1:0] sum_q;
    logic         unused_bits;

    assign sum_q         = stg_p[N_SLICE].sum[W-1:0];
    assign bus.out_valid = stg_p[N_SLICE].v;
    assign bus.sum       = sum_q;
    assign bus.co        = stg_p[N_SLICE].c;
    assign bus.ovf       = (stg_p[N_SLICE].a_msb == stg_p[N_SLICE].b_msb) &&
                           (sum_q[W-1] != stg_p[N_SLICE].a_msb);

    assign unused_bits = ^{stg_p[N_SLICE], gg_unused, pg_unused};

endmodule
